// File: rtl/cf_math_pkg.sv
// Shared math helpers for the common-cells style blocks.
// idx_width(n) gives the index width needed to address n entries (min 1 bit).
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-Max counter used for the FIFO read and write pointers.
// Counts 0..Max-1 and wraps to 0; a clear always wins over an increment.
module wrap_counter
  import cf_math_pkg::*;
#(
  parameter int unsigned Max = 4,
  localparam int unsigned W = idx_width(Max)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_d, q_q;

  // Next count: clear, wrap at Max-1, or plain increment.
  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d = '0;
    end else if (en_i) begin
      if (q_q == W'(Max - 1)) begin
        q_d = '0;
      end else begin
        q_d = q_q + W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/stream_fifo_flushable.sv
// Flushable ready/valid FIFO with registered outputs and no fall-through.
// Storage is a flop array addressed by two wrap_counter pointers plus an
// occupancy counter, so any Depth >= 2 works (not only powers of two).
// flush_i empties the FIFO in one cycle without touching memory contents.
// Optional macro COMMON_CELLS_FIFO_FLUSH_GUARD_EN: when defined, ready_o is
// held low during flush so no upstream beat is lost; when undefined, a beat
// offered during flush handshakes and is dropped (a sim warning flags it).
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high; once valid_o is high, valid_o and data_o hold until popped or flushed.
module stream_fifo_flushable
  import cf_math_pkg::*;
#(
  parameter type T = logic,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = idx_width(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  T                data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output T                data_o,
  output logic [CntW-1:0] usage_o
);

  logic [PtrW-1:0] wptr, rptr;
  logic [CntW-1:0] cnt_d, cnt_q;
  T                mem_d [Depth];
  T                mem_q [Depth];
  logic            push, pop;
  logic            not_full;

  assign not_full = (cnt_q != CntW'(Depth));

`ifdef COMMON_CELLS_FIFO_FLUSH_GUARD_EN
  assign ready_o = not_full && !flush_i;
`else
  assign ready_o = not_full;
`endif

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rptr];
  assign usage_o = cnt_q;

  // Transfers that actually change state; a flush cancels both.
  assign push = valid_i && ready_o && !flush_i;
  assign pop  = valid_o && ready_i && !flush_i;

  wrap_counter #(.Max(Depth)) u_wptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .en_i    (push),
    .q_o     (wptr)
  );

  wrap_counter #(.Max(Depth)) u_rptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .en_i    (pop),
    .q_o     (rptr)
  );

  // Occupancy: flush empties, otherwise +push -pop.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Memory write: only the slot under the write pointer changes on a push.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wptr] = data_i;
    end
  end

  // State registers; reset also clears memory so data_o reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

`ifndef COMMON_CELLS_FIFO_FLUSH_GUARD_EN
`ifndef SYNTHESIS
  // Upstream must not offer a beat during flush; such a beat is discarded.
  flush_valid_warn : assert property (
    @(posedge clk_i) disable iff (!rst_ni) flush_i |-> !valid_i
  ) else $warning("stream_fifo_flushable: valid_i high during flush_i, beat discarded");
`endif
`endif

endmodule

// File: tb/tb_stream_fifo_flushable.sv
// Bench for stream_fifo_flushable: a Depth=4 and a Depth=3 instance.
// A queue model per instance predicts outputs every cycle; directed steps
// add literal expectations for fill, full+pop, flush, reset and streaming.
module tb_stream_fifo_flushable;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       f4, v4, r4, ready4, valid4;
  byte_t      d4, q4;
  logic [2:0] use4;
  logic       f3, v3, r3, ready3, valid3;
  byte_t      d3, q3;
  logic [1:0] use3;

  int n_checks = 0;
  int n_pass   = 0;
  byte_t m4[$];
  byte_t m3[$];
  byte_t log3[$];

  stream_fifo_flushable #(.T(byte_t), .Depth(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f4), .valid_i(v4), .ready_o(ready4),
    .data_i(d4), .valid_o(valid4), .ready_i(r4), .data_o(q4), .usage_o(use4)
  );

  stream_fifo_flushable #(.T(byte_t), .Depth(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f3), .valid_i(v3), .ready_o(ready3),
    .data_i(d3), .valid_o(valid3), .ready_i(r3), .data_o(q3), .usage_o(use3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic exp_ready(input int sz, input int depth, input logic f);
`ifdef COMMON_CELLS_FIFO_FLUSH_GUARD_EN
    return (sz != depth) && !f;
`else
    return (sz != depth) || (f && !f);
`endif
  endfunction

  // Model: a FIFO is a queue; flush empties it, pop/push judged on pre-edge size.
  always @(posedge clk) begin
    if (!rst_n) begin
      m4.delete();
      m3.delete();
    end else begin
      if (f4) m4.delete();
      else begin
        automatic logic pu = v4 && (m4.size() != 4);
        automatic logic po = (m4.size() != 0) && r4;
        if (po) void'(m4.pop_front());
        if (pu) m4.push_back(d4);
      end
      if (valid3 && r3 && !f3) log3.push_back(q3);
      if (f3) m3.delete();
      else begin
        automatic logic pu = v3 && (m3.size() != 3);
        automatic logic po = (m3.size() != 0) && r3;
        if (po) void'(m3.pop_front());
        if (pu) m3.push_back(d3);
      end
    end
  end

  // Compare process: outputs against the model, mid-cycle after inputs settle.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("m4_ready", 32'(ready4), 32'(exp_ready(m4.size(), 4, f4)));
      chk("m4_valid", 32'(valid4), 32'(m4.size() != 0));
      chk("m4_usage", 32'(use4), 32'(m4.size()));
      if (m4.size() != 0) chk("m4_data", 32'(q4), 32'(m4[0]));
      chk("m3_ready", 32'(ready3), 32'(exp_ready(m3.size(), 3, f3)));
      chk("m3_valid", 32'(valid3), 32'(m3.size() != 0));
      chk("m3_usage", 32'(use3), 32'(m3.size()));
      if (m3.size() != 0) chk("m3_data", 32'(q3), 32'(m3[0]));
    end
  end

  task automatic step4(input logic v, input byte_t d, input logic r, input logic f);
    @(negedge clk);
    v4 = v; d4 = d; r4 = r; f4 = f;
    #3;
  endtask

  task automatic step3(input logic v, input byte_t d, input logic r, input logic f);
    @(negedge clk);
    v3 = v; d3 = d; r3 = r; f3 = f;
    #3;
  endtask

  // Mixed push/pop vectors for Depth=4: {valid, ready, flush, data}.
  logic [10:0] vec [14];
  initial begin
    vec[0]  = {3'b100, 8'h01}; vec[1]  = {3'b100, 8'h02};
    vec[2]  = {3'b110, 8'h03}; vec[3]  = {3'b110, 8'h04};
    vec[4]  = {3'b010, 8'h00}; vec[5]  = {3'b100, 8'h05};
    vec[6]  = {3'b100, 8'h06}; vec[7]  = {3'b110, 8'h07};
    vec[8]  = {3'b100, 8'h08}; vec[9]  = {3'b010, 8'h00};
    vec[10] = {3'b010, 8'h00}; vec[11] = {3'b010, 8'h00};
    vec[12] = {3'b010, 8'h00}; vec[13] = {3'b010, 8'h00};
  end

  initial begin
    rst_n = 1'b0;
    f4 = 0; v4 = 0; r4 = 0; d4 = '0;
    f3 = 0; v3 = 0; r3 = 0; d3 = '0;
    #1;
    chk("rst_ready", 32'(ready4), 32'd1);
    chk("rst_valid", 32'(valid4), 32'd0);
    chk("rst_usage", 32'(use4), 32'd0);
    chk("rst_data", 32'(q4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two beats in, then an asynchronous reset mid-cycle.
    step4(1, 8'h11, 0, 0);
    step4(1, 8'h22, 0, 0);
    step4(0, 8'h00, 0, 0);
    chk("pre_rst_usage", 32'(use4), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(ready4), 32'd1);
    chk("async_rst_valid", 32'(valid4), 32'd0);
    chk("async_rst_usage", 32'(use4), 32'd0);
    chk("async_rst_data", 32'(q4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill to full with downstream stalled; the fifth beat is refused.
    for (int i = 0; i < 5; i++) begin
      step4(1, 8'hA1 + 8'(i), 0, 0);
      chk("fill_usage", 32'(use4), 32'(i));
    end
    chk("full_ready", 32'(ready4), 32'd0);
    step4(0, 8'h00, 0, 0);
    chk("full_usage", 32'(use4), 32'd4);
    chk("full_head", 32'(q4), 32'hA1);

    // Pop while full with valid_i high: no push that cycle.
    step4(1, 8'hB0, 1, 0);
    step4(0, 8'h00, 0, 0);
    chk("fullpop_usage", 32'(use4), 32'd3);
    chk("fullpop_ready", 32'(ready4), 32'd1);
    chk("fullpop_head", 32'(q4), 32'hA2);

    // Flush with three entries, then a fresh beat must not show stale data.
    step4(0, 8'h00, 0, 1);
    step4(0, 8'h00, 0, 0);
    chk("flush_usage", 32'(use4), 32'd0);
    chk("flush_valid", 32'(valid4), 32'd0);
    step4(1, 8'h55, 0, 0);
    step4(0, 8'h00, 0, 0);
    chk("post_flush_valid", 32'(valid4), 32'd1);
    chk("post_flush_data", 32'(q4), 32'h55);
    chk("post_flush_usage", 32'(use4), 32'd1);
    step4(0, 8'h00, 1, 0);
    step4(0, 8'h00, 0, 0);
    chk("drain_usage", 32'(use4), 32'd0);

    // Beat offered during flush.
    step4(1, 8'h77, 0, 1);
`ifdef COMMON_CELLS_FIFO_FLUSH_GUARD_EN
    chk("flush_beat_ready", 32'(ready4), 32'd0);
`else
    chk("flush_beat_ready", 32'(ready4), 32'd1);
`endif
    step4(0, 8'h00, 0, 0);
    chk("flush_beat_usage", 32'(use4), 32'd0);
    chk("flush_beat_valid", 32'(valid4), 32'd0);

    // Mixed traffic, checked by the model only.
    for (int i = 0; i < 14; i++) begin
      step4(vec[i][10], vec[i][7:0], vec[i][9], vec[i][8]);
    end
    step4(0, 8'h00, 0, 0);

    // Depth=3 streaming: pointers wrap repeatedly, occupancy stays at 1.
    for (int i = 0; i < 10; i++) begin
      step3(1, 8'(i), 1, 0);
      if (i > 0) chk("stream_usage", 32'(use3), 32'd1);
    end
    step3(0, 8'h00, 1, 0);
    step3(0, 8'h00, 1, 0);
    chk("stream_count", 32'(log3.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < log3.size()) chk("stream_order", 32'(log3[k]), 32'(k));
    end

    step3(0, 8'h00, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_fifo_flushable.md
# stream_fifo_flushable

Parameterised, flushable ready/valid FIFO that sits directly upstream of the flushable spill register, buffering bursts and presenting a registered output. It accepts the same `flush_i` as the downstream spill register so a pipeline flush empties both stages in the same cycle. Storage is a flop array with wrapping read/write pointers and an occupancy counter. Non-power-of-two depths are supported.

## Interface
- `T`, default `logic`: payload type.
- `Depth`, default `4`: number of entries; legal range is `Depth >= 2`.
- `clk_i`  input  1  clock, all state updates on rising edge.
- `rst_ni`  input  1  reset; one clock; reset is asynchronous and active-low.
- `flush_i`  input  1  synchronous flush, clears all entries.
- `valid_i`  input  1  upstream data valid.
- `ready_o`  output  1  FIFO can accept a beat.
- `data_i`  input  T  upstream payload.
- `valid_o`  output  1  head entry present.
- `ready_i`  input  1  downstream (spill register) ready.
- `data_o`  output  T  head entry payload.
- `usage_o`  output  `$clog2(Depth+1)`  current number of stored entries.

## Operation
- State:
  - write pointer `wptr`, width `idx_width(Depth)`.
  - read pointer `rptr`, width `idx_width(Depth)`.
  - count `cnt`, width `$clog2(Depth+1)`.
  - memory `mem[Depth]`.
- Push when `valid_i && ready_o && !flush_i`:
  - Writes `mem[wptr]`.
  - `wptr` increments, wrapping from `Depth-1` to `0`.
- Pop when `valid_o && ready_i && !flush_i`:
  - `rptr` increments, wrapping from `Depth-1` to `0`.
- Count update:
  - `cnt += push - pop`.
  - Push and pop in the same cycle leave `cnt` unchanged.
- `ready_o = (cnt != Depth)`; gating by flush is covered in Configuration.
- `valid_o = (cnt != 0)`.
- `data_o = mem[rptr]`.
- `usage_o = cnt`.
- Full:
  - `ready_o` is 0.
  - A pop in the full cycle does not enable a push in that same cycle; there is no combinational ready path from `ready_i` to `ready_o`.
- Empty:
  - `valid_o` is 0.
  - There is no fall-through: a beat pushed into an empty FIFO appears on `valid_o` one cycle later.
- Flush (`flush_i` high):
  - Next cycle: `wptr`, `rptr` and `cnt` are 0.
  - Memory contents are untouched.
  - Pops and pushes in the flush cycle have no effect.
- Reset mid-operation:
  - Pointers, count and all memory entries clear asynchronously to 0.
  - Any beat in flight is lost.

## Timing
- Reset values:
  - `ready_o` = 1.
  - `valid_o` = 0.
  - `data_o` = `'0`.
  - `usage_o` = 0.
- Latency: push in cycle N → `valid_o` high in cycle N+1.
- Throughput: one beat per cycle sustained when neither full nor empty.
- Output timing:
  - `valid_o`, `data_o` and `usage_o` are registered-state derived only; there is no path from any input.
  - `ready_o` depends on state only, plus `flush_i` when the guard is enabled.
- Handshake:
  - A beat transfers on the rising edge where valid and ready are both high.
  - Once `valid_o` is asserted, it and `data_o` stay stable until popped or flushed.

## Configuration
- Macro: `COMMON_CELLS_FIFO_FLUSH_GUARD_EN`.
- Defined:
  - `ready_o` is forced to 0 while `flush_i` is high, so no upstream handshake completes in a flush cycle.
  - No data is silently dropped.
- Not defined:
  - `ready_o` ignores `flush_i`.
  - A beat offered during flush completes its handshake upstream but is discarded.
  - The upstream must not assert `valid_i` with `flush_i`.
  - A simulation-only warning assertion (`flush_i |-> !valid_i`) is included in this mode.

## Structure
- Shared package `cf_math_pkg` provides `idx_width(n)`, which returns `n > 1 ? $clog2(n) : 1` and sizes both pointers.
- No new typedefs are needed; `T` is supplied by the instantiating parent.
- One sub-module: `wrap_counter`.
  - Ports: `clk_i`, `rst_ni`, `clear_i`, `en_i`, `q_o`.
  - Parameter `Max`.
  - Increments when enabled and wraps from `Max-1` to 0; `clear_i` has priority over `en_i`.
  - Instantiated twice, once for `wptr` and once for `rptr`.

## Test plan
- Reset check, `Depth=4`: assert `rst_ni` low asynchronously mid-cycle → `ready_o`=1, `valid_o`=0, `usage_o`=0, `data_o`=0 immediately.
- Fill to full, `Depth=4`, `ready_i`=0: push 0xA1..0xA4 → `usage_o` goes 1,2,3,4; `ready_o`=0 after the 4th beat; a 5th `valid_i` is not accepted.
- Streaming, `Depth=3`, `ready_i`=1, continuous push of 0..9 → output 0..9 in order with one-cycle latency; both pointers wrap 2→0 three times; `usage_o` stays 1.
- Full plus pop: full FIFO, `ready_i`=1 for one cycle with `valid_i`=1 → head popped, no push that cycle, `usage_o`=3, `ready_o`=1 next cycle.
- Flush with 3 entries held → next cycle `usage_o`=0, `valid_o`=0; a subsequent push of 0x55 is output as 0x55, not stale data.
- Flush with `valid_i`=1 and data 0x77:
  - Guard defined: `ready_o`=0 and no handshake occurs.
  - Guard not defined: `ready_o`=1, the beat is dropped, the warning fires, and `usage_o`=0.
